// File: rtl/time_parameter.sv
// Programmable timing parameters (base green, extended green, yellow) for the
// traffic light controller, with a combinational read port for the timer.
module time_parameter #(
    parameter logic [3:0] DEF_BASE = 4'd6,
    parameter logic [3:0] DEF_EXT  = 4'd3,
    parameter logic [3:0] DEF_YEL  = 4'd2
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [1:0] Selector,
    input  logic [3:0] Time_value,
    input  logic       Prog_Sync,
    input  logic [1:0] interval,
    output logic [3:0] value
);

    localparam int NUM_PARAMS = 3;

    localparam logic [1:0] SEL_BASE = 2'b00;
    localparam logic [1:0] SEL_EXT  = 2'b01;
    localparam logic [1:0] SEL_YEL  = 2'b10;

    // Slot order matches the Selector/interval encoding: 0=base, 1=ext, 2=yel.
    localparam logic [NUM_PARAMS-1:0][3:0] DEFAULTS = {DEF_YEL, DEF_EXT, DEF_BASE};

    logic [NUM_PARAMS-1:0][3:0] param_reg;
    logic [NUM_PARAMS-1:0]      write_en;
    logic                       write_valid;

    logic [3:0] reg_base;
    logic [3:0] reg_ext;
    logic [3:0] reg_yel;

    // A zero duration would stall the countdown, so such writes are dropped.
    assign write_valid = Prog_Sync && (Time_value != 4'd0);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PARAMS; gi++) begin : g_param
            assign write_en[gi] = write_valid && (Selector == 2'(gi));

            always_ff @(posedge clk) begin
                if (Reset) begin
                    param_reg[gi] <= DEFAULTS[gi];
                end else if (write_en[gi]) begin
                    param_reg[gi] <= Time_value;
                end
            end
        end
    endgenerate

    assign reg_base = param_reg[0];
    assign reg_ext  = param_reg[1];
    assign reg_yel  = param_reg[2];

    // Reserved code 11 falls back to the base green time.
    always_comb begin
        value = reg_base;
        case (interval)
            SEL_BASE: value = reg_base;
            SEL_EXT:  value = reg_ext;
            SEL_YEL:  value = reg_yel;
            default:  value = reg_base;
        endcase
    end

endmodule

// File: tb/tb_time_parameter.sv
// Self-checking bench for time_parameter: directed scenarios followed by
// randomized programming traffic checked against a simple parameter-table model.
module tb_time_parameter;

    logic       clk = 1'b0;
    logic       Reset;
    logic [1:0] Selector;
    logic [3:0] Time_value;
    logic       Prog_Sync;
    logic [1:0] interval;
    logic [3:0] value;

    int checks = 0;
    int errors = 0;

    // Model: the three stored durations, indexed base/ext/yel.
    int model[3];

    time_parameter dut (
        .clk        (clk),
        .Reset      (Reset),
        .Selector   (Selector),
        .Time_value (Time_value),
        .Prog_Sync  (Prog_Sync),
        .interval   (interval),
        .value      (value)
    );

    always #5 clk = ~clk;

    function automatic int expected_value(input logic [1:0] iv);
        if (iv == 2'd3) return model[0];
        return model[iv];
    endfunction

    task automatic check_value(input string tag, input logic [3:0] got, input int exp);
        checks++;
        if (got !== 4'(exp)) begin
            errors++;
            $display("FAIL %s interval=%0d got %0d expected %0d", tag, interval, got, exp);
        end else begin
            $display("ok   %s interval=%0d value=%0d", tag, interval, got);
        end
    endtask

    // Advance one rising edge, apply the stored-parameter rules to the model,
    // then settle 1ns past the edge.
    task automatic tick();
        @(posedge clk);
        if (Reset) begin
            model[0] = 6;
            model[1] = 3;
            model[2] = 2;
        end else if (Prog_Sync && Selector != 2'd3 && Time_value != 4'd0) begin
            model[Selector] = int'(Time_value);
        end
        #1;
    endtask

    task automatic sweep(input string tag);
        for (int iv = 0; iv < 4; iv++) begin
            interval = 2'(iv);
            #1;
            check_value(tag, value, expected_value(interval));
        end
    endtask

    initial begin
        Reset = 1'b1; Selector = 2'd0; Time_value = 4'd0; Prog_Sync = 1'b0; interval = 2'd0;
        model[0] = 0; model[1] = 0; model[2] = 0;

        // 1: reset defaults, checked against literal constants as well
        tick(); tick();
        Reset = 1'b0;
        interval = 2'd0; #1; check_value("rst_base", value, 6);
        interval = 2'd1; #1; check_value("rst_ext",  value, 3);
        interval = 2'd2; #1; check_value("rst_yel",  value, 2);
        interval = 2'd3; #1; check_value("rst_rsvd", value, 6);

        // 2: program tEXT to 15
        Prog_Sync = 1'b1; Selector = 2'd1; Time_value = 4'hF;
        tick();
        Prog_Sync = 1'b0;
        interval = 2'd1; #1; check_value("prog_ext", value, 15);
        interval = 2'd0; #1; check_value("prog_ext_base_hold", value, 6);
        interval = 2'd2; #1; check_value("prog_ext_yel_hold", value, 2);

        // 3: zero write and reserved selector are both ignored
        Prog_Sync = 1'b1; Selector = 2'd2; Time_value = 4'd0;
        tick();
        interval = 2'd2; #1; check_value("zero_write", value, 2);
        Selector = 2'd3; Time_value = 4'd9;
        tick();
        Prog_Sync = 1'b0;
        sweep("rsvd_sel");

        // 4: level-sensitive enable, each new value lands one edge later
        interval = 2'd0; Selector = 2'd0; Prog_Sync = 1'b1;
        Time_value = 4'd4; tick(); check_value("hold_4", value, 4);
        Time_value = 4'd7; #1; check_value("hold_pre7", value, 4);
        tick(); check_value("hold_7", value, 7);
        Time_value = 4'd12; #1; check_value("hold_pre12", value, 7);
        tick(); check_value("hold_12", value, 12);

        // 5: reset wins over a simultaneous write
        Selector = 2'd0; Time_value = 4'd9; Reset = 1'b1;
        tick();
        Reset = 1'b0; Prog_Sync = 1'b0;
        interval = 2'd0; #1; check_value("rst_prio_base", value, 6);
        sweep("rst_prio");

        // 6: Prog_Sync low, random inputs, value follows interval in-cycle
        for (int i = 0; i < 20; i++) begin
            Selector   = 2'($urandom_range(0, 3));
            Time_value = 4'($urandom_range(0, 15));
            interval   = 2'($urandom_range(0, 3));
            #1;
            check_value("idle_comb", value, expected_value(interval));
            tick();
            check_value("idle_post", value, expected_value(interval));
        end

        // Randomized mixed traffic, with occasional resets
        for (int i = 0; i < 300; i++) begin
            Reset      = ($urandom_range(0, 31) == 0);
            Prog_Sync  = $urandom_range(0, 1);
            Selector   = 2'($urandom_range(0, 3));
            Time_value = 4'($urandom_range(0, 15));
            interval   = 2'($urandom_range(0, 3));
            #1;
            check_value("rand_pre", value, expected_value(interval));
            tick();
            check_value("rand_post", value, expected_value(interval));
        end

        Reset = 1'b0; Prog_Sync = 1'b0;
        sweep("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_parameter.md
Name: time_parameter

Overview:
- Holds the three programmable timing parameters of the traffic light controller: base green time (tBASE), extended green time (tEXT) and yellow time (tYEL).
- Each parameter is a 4-bit register loaded with a factory default at reset and reprogrammable from the operator panel via Selector/Time_value/Prog_Sync.
- The FSM/timer block chooses a parameter with `interval`; the selected duration appears on `value` and seeds the countdown timer.

Parameters:
- DEF_BASE, 4'd6, reset/default value of tBASE (seconds)
- DEF_EXT, 4'd3, reset/default value of tEXT
- DEF_YEL, 4'd2, reset/default value of tYEL

Ports:
- clk  input  1  system clock; all state changes on rising edge
- Reset  input  1  synchronous, active-high reset
- Selector  input  2  parameter to program: 00=tBASE, 01=tEXT, 10=tYEL, 11=reserved
- Time_value  input  4  new duration to store (1..15)
- Prog_Sync  input  1  program strobe (synchronised, level-sensitive write enable)
- interval  input  2  parameter to output: 00=tBASE, 01=tEXT, 10=tYEL, 11=reserved
- value  output  4  duration of the parameter selected by `interval`

Behaviour:
- Storage: three 4-bit registers, reg_base, reg_ext and reg_yel.
- Reset: on a rising clk edge with Reset=1:
  - reg_base=DEF_BASE, reg_ext=DEF_EXT, reg_yel=DEF_YEL.
  - Reset has priority over programming.
  - `value` reflects the defaults immediately after that edge.
- Programming: on each rising clk edge with Reset=0 and Prog_Sync=1, the register addressed by Selector loads Time_value.
  - Prog_Sync is a level enable: holding it high rewrites the register every cycle with the current Time_value.
  - Selector or Time_value changes while Prog_Sync is high take effect at the next edge.
  - Selector=11: no register written.
  - Time_value=0: write ignored and the register keeps its old value, so a zero-length interval can never be stored.
  - Only the addressed register changes; the other two hold.
- Output: `value` is a combinational mux of the registers by `interval`.
  - 00 gives reg_base, 01 gives reg_ext, 10 gives reg_yel.
  - 11 gives reg_base (safe default).
  - No added latency: an `interval` change shows on `value` in the same cycle.
  - A register write shows on `value` right after the writing edge.
- Simultaneous write and read of the same parameter: `value` shows the old content until the edge and the new content after it. There is no bypass.
- Before the first reset, register contents are undefined. The system must assert Reset at power-up.
- Reset mid-programming: all registers return to defaults and that cycle's write is discarded.
- Range: values 1..15 are representable and there is no other saturation or wrap logic.

Test Plan:
1. Reset=1 for 2 cycles, then Reset=0; sweep interval 00/01/10/11 -> value = 6, 3, 2, 6.
2. Prog_Sync=1, Selector=01, Time_value=4'hF for one edge, then interval=01 -> value=15; interval=00 -> 6 and interval=10 -> 2 (unchanged).
3. Prog_Sync=1, Selector=10, Time_value=0 -> reg_yel stays 2. Selector=11, Time_value=9 -> all registers unchanged (6/3/2 or current).
4. Prog_Sync held high while Time_value steps 4 -> 7 -> 12 with Selector=00 -> value (interval=00) follows 4, 7, 12, each one edge after the input changes.
5. Prog_Sync=1 and Reset=1 on the same edge, Selector=00, Time_value=9 -> value (interval=00) = 6; defaults restored for all three parameters.
6. Prog_Sync=0 with random Selector/Time_value for 20 cycles -> no register changes; value tracks interval combinationally within the same cycle.
